// File: rtl/axi_sub_write_burst_if_if.sv
// AXI-style write channel bundle (AW/W/B) between a manager and the burst write subordinate.
interface axi_sub_write_burst_if_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [LEN_WIDTH-1:0]    awlen;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic                    wlast;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awlen, awvalid, wdata, wstrb, wvalid, wlast, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wstrb, wvalid, wlast, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_sub_write_burst_if.sv
// Single-outstanding AXI-style write burst subordinate: one registered local write per beat,
// SLVERR on out-of-range bursts or misplaced WLAST.
module axi_sub_write_burst_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int MAX_ADDR   = 2**ADDR_WIDTH-1
) (
  input  logic                    s_axi_clk,
  input  logic                    s_axi_resetn,
  axi_sub_write_burst_if_if.slave s_axi,
  output logic [ADDR_WIDTH-1:0]   w_addr,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    write_enable
);
  localparam int STRB_W = DATA_WIDTH/8;
  localparam int SUM_W  = ADDR_WIDTH+LEN_WIDTH+1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_err;
  logic                  r_lerr;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_we;

  logic [SUM_W-1:0]      w_sum;
  logic                  w_range_err;
  logic                  w_aw_hs;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_lmis;

  // Extra headroom bit keeps base+len from wrapping back into range.
  assign w_sum       = SUM_W'(s_axi.awaddr) + SUM_W'(s_axi.awlen);
  assign w_range_err = w_sum > SUM_W'(MAX_ADDR);
  assign w_aw_hs     = s_axi.awvalid & r_awready;
  assign w_beat      = s_axi.wvalid & r_wready;
  assign w_last      = (r_cnt == r_len);
  assign w_lmis      = s_axi.wlast != w_last;

  always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
    if (!s_axi_resetn) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_lerr    <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_we      <= 1'b0;
    end else begin
      // Local write port is zero on every cycle that does not follow an accepted beat.
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      case (r_state)
        S_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_base    <= s_axi.awaddr;
            r_len     <= s_axi.awlen;
            r_cnt     <= '0;
            r_err     <= w_range_err;
            r_lerr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            if (!r_err) begin
              r_we    <= 1'b1;
              r_waddr <= r_base + ADDR_WIDTH'(r_cnt);
              r_wdata <= s_axi.wdata;
              r_wstrb <= s_axi.wstrb;
            end
            r_cnt <= r_cnt + LEN_WIDTH'(1);
            if (w_lmis) r_lerr <= 1'b1;
            // Burst length comes from AWLEN; WLAST only affects the response.
            if (w_last) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_err | r_lerr | w_lmis) ? 2'b10 : 2'b00;
              r_state  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (s_axi.bready) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_awready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
          r_bresp   <= 2'b00;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign w_addr        = r_waddr;
  assign wdata         = r_wdata;
  assign wstrb         = r_wstrb;
  assign write_enable  = r_we;
endmodule

// File: tb/tb_axi_sub_write_burst_if.sv
// Directed bench for the write burst subordinate; a negedge monitor checks local writes and B responses
// against queues filled by the stimulus.
module tb_axi_sub_write_burst_if;
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       strb;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] w_addr;
  logic [7:0] wdata;
  logic [0:0] wstrb;
  logic       write_enable;

  int  n_cmp = 0;
  int  n_err = 0;
  wr_t exp_wr[$];
  logic [1:0] exp_b[$];
  logic prev_hs = 1'b0;

  always #5 clk = ~clk;

  axi_sub_write_burst_if_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(8)) bus ();

  axi_sub_write_burst_if #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(8), .MAX_ADDR(240)
  ) dut (
    .s_axi_clk    (clk),
    .s_axi_resetn (rst_n),
    .s_axi        (bus),
    .w_addr       (w_addr),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .write_enable (write_enable)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting, expected handshake at %0t", name, $time);
  endtask

  // Monitor: every local write and every B handshake must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (write_enable) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write_en", 32'(write_enable), 32'd0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(w_addr), 32'(e.addr));
          chk("wr_data", 32'(wdata), 32'(e.data));
          chk("wr_strb", 32'(wstrb), 32'(e.strb));
          chk("wr_latency", 32'(prev_hs), 32'd1);
        end
      end
      if (bus.bvalid && bus.bready) begin
        if (exp_b.size() == 0) begin
          chk("unexpected_b", 32'(bus.bvalid), 32'd0);
        end else begin
          logic [1:0] eb;
          eb = exp_b.pop_front();
          chk("bresp", 32'(bus.bresp), 32'(eb));
        end
      end
      prev_hs = bus.wvalid && bus.wready;
    end
  end

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d, input logic s);
    wr_t e;
    e.addr = a; e.data = d; e.strb = s;
    exp_wr.push_back(e);
  endtask

  task automatic aw(input logic [7:0] a, input logic [7:0] l);
    logic hs;
    logic done;
    done = 1'b0;
    bus.awaddr = a; bus.awlen = l; bus.awvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); hs = bus.awready;
      @(posedge clk); #1;
      if (hs) done = 1'b1;
    end
    bus.awvalid = 1'b0;
    if (!done) timeout("aw_handshake");
  endtask

  task automatic beat(input logic [7:0] d, input logic s, input logic last, input int gap);
    logic hs;
    logic done;
    done = 1'b0;
    if (gap > 0) begin
      bus.wvalid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    bus.wdata = d; bus.wstrb = s; bus.wlast = last; bus.wvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); hs = bus.wready;
      @(posedge clk); #1;
      if (hs) done = 1'b1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    if (!done) timeout("w_handshake");
  endtask

  task automatic wait_b();
    for (int i = 0; i < 50 && exp_b.size() != 0; i++) @(negedge clk);
    if (exp_b.size() != 0) timeout("b_handshake");
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, 32'(bus.awready), 32'd0);
    chk({tag, "_wready"}, 32'(bus.wready), 32'd0);
    chk({tag, "_bvalid"}, 32'(bus.bvalid), 32'd0);
    chk({tag, "_bresp"}, 32'(bus.bresp), 32'd0);
    chk({tag, "_we"}, 32'(write_enable), 32'd0);
    chk({tag, "_waddr"}, 32'(w_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(wdata), 32'd0);
    chk({tag, "_wstrb"}, 32'(wstrb), 32'd0);
  endtask

  task automatic release_reset(input string tag);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk({tag, "_awready_at_release"}, 32'(bus.awready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk({tag, "_awready_after_release"}, 32'(bus.awready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b1;

    // Reset state, then release.
    repeat (3) @(posedge clk);
    @(negedge clk); chk_all_zero("reset");
    release_reset("rst1");

    // Reset asserted in the cycle a beat's write strobe is high.
    aw(8'h30, 8'd3);
    beat(8'h99, 1'b1, 1'b0, 0);
    chk("midburst_we_before_reset", 32'(write_enable), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midburst_reset");
    release_reset("rst2");

    // Single beat; W offered before AW must stall without loss.
    bus.wdata = 8'hA5; bus.wstrb = 1'b1; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("w_before_aw_stalled", 32'(bus.wready), 32'd0);
      @(posedge clk); #1;
    end
    push_wr(8'h10, 8'hA5, 1'b1); exp_b.push_back(2'b00);
    aw(8'h10, 8'd0);
    beat(8'hA5, 1'b1, 1'b1, 0);
    wait_b();

    // Burst with gaps, including an all-zero strobe beat.
    push_wr(8'h20, 8'h11, 1'b1); push_wr(8'h21, 8'h22, 1'b0);
    push_wr(8'h22, 8'h33, 1'b1); push_wr(8'h23, 8'h44, 1'b1);
    exp_b.push_back(2'b00);
    aw(8'h20, 8'd3);
    beat(8'h11, 1'b1, 1'b0, 1);
    beat(8'h22, 1'b0, 1'b0, 0);
    beat(8'h33, 1'b1, 1'b0, 2);
    beat(8'h44, 1'b1, 1'b1, 1);
    wait_b();

    // Last address exactly MAX_ADDR: legal.
    push_wr(8'hED, 8'h01, 1'b1); push_wr(8'hEE, 8'h02, 1'b1);
    push_wr(8'hEF, 8'h03, 1'b1); push_wr(8'hF0, 8'h04, 1'b1);
    exp_b.push_back(2'b00);
    aw(8'hED, 8'd3);
    beat(8'h01, 1'b1, 1'b0, 0); beat(8'h02, 1'b1, 1'b0, 0);
    beat(8'h03, 1'b1, 1'b0, 0); beat(8'h04, 1'b1, 1'b1, 0);
    wait_b();

    // One past MAX_ADDR: beats accepted, nothing written, SLVERR.
    exp_b.push_back(2'b10);
    aw(8'hEE, 8'd3);
    beat(8'h05, 1'b1, 1'b0, 0); beat(8'h06, 1'b1, 1'b0, 0);
    beat(8'h07, 1'b1, 1'b0, 0); beat(8'h08, 1'b1, 1'b1, 0);
    wait_b();

    // WLAST on beat 1 of 4: all beats written, SLVERR; next burst clean.
    push_wr(8'h40, 8'hB0, 1'b1); push_wr(8'h41, 8'hB1, 1'b1);
    push_wr(8'h42, 8'hB2, 1'b1); push_wr(8'h43, 8'hB3, 1'b1);
    exp_b.push_back(2'b10);
    aw(8'h40, 8'd3);
    beat(8'hB0, 1'b1, 1'b0, 0); beat(8'hB1, 1'b1, 1'b1, 0);
    beat(8'hB2, 1'b1, 1'b0, 0); beat(8'hB3, 1'b1, 1'b0, 0);
    wait_b();
    push_wr(8'h50, 8'hC0, 1'b1); push_wr(8'h51, 8'hC1, 1'b1);
    exp_b.push_back(2'b00);
    aw(8'h50, 8'd1);
    beat(8'hC0, 1'b1, 1'b0, 0); beat(8'hC1, 1'b1, 1'b1, 0);
    wait_b();

    // B stall with a competing AW.
    bus.bready = 1'b0;
    push_wr(8'h60, 8'h66, 1'b1); exp_b.push_back(2'b00);
    aw(8'h60, 8'd0);
    beat(8'h66, 1'b1, 1'b1, 0);
    bus.awaddr = 8'h70; bus.awlen = 8'd0; bus.awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_bvalid", 32'(bus.bvalid), 32'd1);
      chk("stall_bresp", 32'(bus.bresp), 32'd0);
      chk("stall_awready", 32'(bus.awready), 32'd0);
      @(posedge clk); #1;
    end
    bus.bready = 1'b1;
    @(negedge clk); chk("b_hs_cycle_awready", 32'(bus.awready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("after_b_awready", 32'(bus.awready), 32'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    @(negedge clk); chk("aw_taken_wready", 32'(bus.wready), 32'd1);
    push_wr(8'h70, 8'h77, 1'b1); exp_b.push_back(2'b00);
    @(posedge clk); #1;
    beat(8'h77, 1'b1, 1'b1, 0);
    wait_b();

    repeat (3) @(posedge clk);
    chk("leftover_writes", 32'(exp_wr.size()), 32'd0);
    chk("leftover_bresp", 32'(exp_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
